// File: rtl/sfgen_arith_pkg.sv
// Shared constants and types for the SFGen 16-bit two's-complement arithmetic blocks.
package sfgen_arith_pkg;

   localparam int unsigned TC16_W   = 16;
   localparam logic [15:0] TC16_MIN = 16'h8000;

   typedef logic signed [15:0] tc16_t;

endpackage

// File: rtl/tc_neg_16.sv
// 16-bit two's-complement negation as invert-plus-one over an explicit ripple carry chain.
module tc_neg_16
   import sfgen_arith_pkg::*;
(
   input  logic [TC16_W-1:0] a,
   output logic [TC16_W-1:0] neg
);

   logic [TC16_W-1:0] inv;
   logic              carry;

   assign inv = ~a;

   // The +1 enters as carry-in at bit 0 and ripples while the inverted bits stay 1.
   always_comb begin
      neg   = '0;
      carry = 1'b1;
      for (int i = 0; i < int'(TC16_W); i++) begin
         neg[i] = inv[i] ^ carry;
         carry  = inv[i] & carry;
      end
   end

endmodule

// File: rtl/tc_abs16.sv
// Two's-complement absolute value: combinational |a| with overflow flag plus a one-cycle
// registered copy qualified by in_valid.
module tc_abs16
   import sfgen_arith_pkg::*;
#(
   parameter int unsigned WIDTH = TC16_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic             in_valid,
   output logic [WIDTH-1:0] fs_0,
   output logic             ovf,
   output logic [WIDTH-1:0] fs_0_q,
   output logic             ovf_q,
   output logic             out_valid
);

   logic [WIDTH-1:0] neg;
   logic [WIDTH-1:0] fs_0_d;
   logic             ovf_d;

   tc_neg_16 u_neg (
      .a   (a),
      .neg (neg)
   );

   assign fs_0 = a[WIDTH-1] ? neg : a;
   // Only the most negative value has no positive counterpart; its negation wraps to itself.
   assign ovf  = (a == TC16_MIN);

   always_comb begin
      fs_0_d = fs_0_q;
      ovf_d  = ovf_q;
      if (in_valid) begin
         fs_0_d = fs_0;
         ovf_d  = ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fs_0_q    <= '0;
         ovf_q     <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         fs_0_q    <= fs_0_d;
         ovf_q     <= ovf_d;
         out_valid <= in_valid;
      end
   end

endmodule

// File: tb/tb_tc_abs16.sv
// Self-checking bench for tc_abs16: directed boundaries, random pipelined traffic, full sweep.
module tb_tc_abs16;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a;
   logic        in_valid;
   logic [15:0] fs_0;
   logic        ovf;
   logic [15:0] fs_0_q;
   logic        ovf_q;
   logic        out_valid;

   int n_assert = 0;
   int n_fail   = 0;

   // Expected registered state, advanced once per clock edge.
   logic [15:0] m_val;
   logic        m_ovf;
   logic        m_vld;

   tc_abs16 #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .in_valid  (in_valid),
      .fs_0      (fs_0),
      .ovf       (ovf),
      .fs_0_q    (fs_0_q),
      .ovf_q     (ovf_q),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_abs(input logic [15:0] v);
      int s;
      s = $signed(v);
      if (s < 0) s = -s;
      return s[15:0];
   endfunction

   function automatic logic ref_ovf(input logic [15:0] v);
      int s;
      s = $signed(v);
      return (s == -32768);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic comb_check(input string tag, input logic [15:0] v);
      a = v;
      #1;
      check({tag, " fs_0"}, 32'(fs_0), 32'(ref_abs(v)));
      check({tag, " ovf"}, 32'(ovf), 32'(ref_ovf(v)));
   endtask

   // Apply one edge: update the model from current inputs, then sample 1 after the edge.
   task automatic step_and_check(input string tag);
      if (rst) begin
         m_val = '0;
         m_ovf = 1'b0;
         m_vld = 1'b0;
      end else begin
         if (in_valid) begin
            m_val = ref_abs(a);
            m_ovf = ref_ovf(a);
         end
         m_vld = in_valid;
      end
      @(posedge clk);
      #1;
      check({tag, " fs_0_q"}, 32'(fs_0_q), 32'(m_val));
      check({tag, " ovf_q"}, 32'(ovf_q), 32'(m_ovf));
      check({tag, " out_valid"}, 32'(out_valid), 32'(m_vld));
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = 16'h0000;

      // Combinational path, no clock edge needed between change and check.
      comb_check("a=0001", 16'h0001);
      check("a=0001 fs_0 const", 32'(fs_0), 32'h0001);
      comb_check("a=FF16", 16'hFF16);
      check("a=FF16 fs_0 const", 32'(fs_0), 32'h00EA);
      comb_check("a=FFFF", 16'hFFFF);
      check("a=FFFF fs_0 const", 32'(fs_0), 32'h0001);
      comb_check("a=8000", 16'h8000);
      check("a=8000 ovf const", 32'(ovf), 32'h1);
      comb_check("a=7FFF", 16'h7FFF);
      comb_check("a=0000", 16'h0000);

      // Reset held for two edges; combinational output keeps tracking a.
      rst = 1'b1;
      step_and_check("reset1");
      step_and_check("reset2");
      check("reset fs_0_q const", 32'(fs_0_q), 32'h0);
      comb_check("in reset a=FFF0", 16'hFFF0);

      // Back-to-back capture of -5, -32768, 7.
      rst      = 1'b0;
      in_valid = 1'b1;
      a        = 16'hFFFB;
      step_and_check("cap -5");
      check("cap -5 fs_0_q const", 32'(fs_0_q), 32'd5);
      a = 16'h8000;
      step_and_check("cap -32768");
      check("cap -32768 ovf_q const", 32'(ovf_q), 32'h1);
      a = 16'h0007;
      step_and_check("cap 7");
      check("cap 7 fs_0_q const", 32'(fs_0_q), 32'd7);

      // Idle: registers hold, out_valid drops.
      in_valid = 1'b0;
      a        = 16'hFFFF;
      step_and_check("hold1");
      check("hold1 fs_0_q const", 32'(fs_0_q), 32'd7);
      step_and_check("hold2");

      // Reset mid-stream drops the in-flight sample and wins over in_valid.
      in_valid = 1'b1;
      a        = 16'hFF9C;
      rst      = 1'b1;
      step_and_check("mid reset");
      rst      = 1'b0;
      in_valid = 1'b0;
      step_and_check("post reset idle");
      in_valid = 1'b1;
      a        = 16'hFF9C;
      step_and_check("first after reset");

      // Random traffic with occasional resets.
      for (int i = 0; i < 300; i++) begin
         rst      = ($urandom_range(0, 15) == 0);
         in_valid = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 7))
            0:       a = 16'h8000;
            1:       a = 16'h0000;
            2:       a = 16'hFFFF;
            default: a = 16'($urandom);
         endcase
         #0;
         check("rand comb fs_0", 32'(fs_0), 32'(ref_abs(a)));
         step_and_check("rand");
      end
      rst      = 1'b0;
      in_valid = 1'b0;

      // Exhaustive combinational sweep.
      for (int v = 0; v < 65536; v++) begin
         a = 16'(v);
         #1;
         check("sweep fs_0", 32'(fs_0), 32'(ref_abs(16'(v))));
         check("sweep ovf", 32'(ovf), 32'(ref_ovf(16'(v))));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
